// File: rtl/comb_sweep_pkg.sv
// rtl/comb_sweep_pkg.sv - shared types and helpers for the combinational sweep controller
package comb_sweep_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} sweep_state_t;

  localparam int N_IN  = 3;
  localparam int N_PAT = 8;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// rtl/sweep_settle_timer.sv - loadable 8-bit settle down-counter
module sweep_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign zero = (cnt == 8'd0);

endmodule

// File: rtl/comb_sweep_ctrl.sv
// rtl/comb_sweep_ctrl.sv - exhaustive 3-input sweep of a combinational block with truth-table check
module comb_sweep_ctrl
  import comb_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected_tt,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt,
  output logic       pass,
  output logic [3:0] err_cnt
);

  localparam logic [7:0]      RELOAD   = 8'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_PAT - 1);

  sweep_state_t    state, next_state;
  logic [N_IN-1:0] idx;
  logic [N_IN-1:0] abc;
  logic [7:0]      exp_tt;
  logic [7:0]      tt_next;
  logic            accept, sample, last, zero;
  logic            tmr_load, tmr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // abort outranks both start (in IDLE) and sampling (in DRIVE)
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    sample     = 1'b0;
    last       = (idx == LAST_IDX);
    tt_next    = tt;
    tt_next[idx] = y;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          next_state = DRIVE;
          accept     = 1'b1;
        end
      end
      DRIVE: begin
        if (abort) begin
          next_state = IDLE;
        end else if (zero) begin
          sample = 1'b1;
          if (last) begin
            next_state = DONE;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign tmr_load = accept || (sample && !last);
  assign tmr_en   = (state == DRIVE);

  sweep_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (RELOAD),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      abc     <= '0;
      exp_tt  <= 8'h00;
      tt      <= 8'h00;
      pass    <= 1'b0;
      err_cnt <= 4'd0;
    end else if (accept) begin
      idx     <= '0;
      abc     <= '0;
      exp_tt  <= expected_tt;
      tt      <= 8'h00;
      pass    <= 1'b0;
      err_cnt <= 4'd0;
    end else if (state == DRIVE) begin
      if (abort) begin
        idx     <= '0;
        abc     <= '0;
        pass    <= 1'b0;
        err_cnt <= 4'd0;
      end else if (sample) begin
        tt <= tt_next;
        if (last) begin
          abc     <= '0;
          pass    <= (tt_next == exp_tt);
          err_cnt <= popcount8(tt_next ^ exp_tt);
        end else begin
          idx <= idx + 1'b1;
          abc <= idx + 1'b1;
        end
      end
    end
  end

  assign a    = abc[2];
  assign b    = abc[1];
  assign c    = abc[0];
  assign busy = (state == DRIVE);
  assign done = (state == DONE);

endmodule
